// File: rtl/accum_arbiter.sv
// Two-requester round-robin accumulator. The new accumulator value is
// converted to three BCD digits with an 8-step double-dabble pass.
module accum_arbiter (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_a_i,
  input  logic        req_b_i,
  input  logic [1:0]  op_a_i,
  input  logic [1:0]  op_b_i,
  input  logic [7:0]  data_a_i,
  input  logic [7:0]  data_b_i,
  output logic        gnt_a_o,
  output logic        gnt_b_o,
  output logic [7:0]  acc_o,
  output logic        overflow_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [11:0] bcd_o,
  output logic        bcd_valid_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // One double-dabble step: add 3 to each BCD nibble >= 5, then shift left.
  function automatic logic [19:0] dd_step(input logic [19:0] sh);
    logic [19:0] t;
    t = sh;
    for (int n = 0; n < 3; n++) begin
      if (t[8+4*n +: 4] >= 4'd5) t[8+4*n +: 4] = t[8+4*n +: 4] + 4'd3;
      else                       t[8+4*n +: 4] = t[8+4*n +: 4];
    end
    return {t[18:0], 1'b0};
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  acc_q, acc_d;
  logic        ov_q, ov_d;
  logic [19:0] shift_q, shift_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] bcd_q, bcd_d;
  logic        bcd_valid_q, bcd_valid_d;
  logic        gnt_a_q, gnt_a_d;
  logic        gnt_b_q, gnt_b_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  // Set when B received the most recent grant; reset to 1 so A wins first.
  logic        last_b_q, last_b_d;
  logic        pick_b_s;
  logic [8:0]  sum_s;

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    acc_d       = acc_q;
    ov_d        = ov_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    bcd_valid_d = bcd_valid_q;
    gnt_a_d     = 1'b0;
    gnt_b_d     = 1'b0;
    done_d      = 1'b0;
    last_b_d    = last_b_q;
    pick_b_s    = req_b_i & (~req_a_i | ~last_b_q);
    sum_s       = {1'b0, acc_q} + {1'b0, data_q};

    case (state_q)
      ST_IDLE: begin
        if (req_a_i | req_b_i) begin
          state_d     = ST_EXEC;
          op_d        = pick_b_s ? op_b_i : op_a_i;
          data_d      = pick_b_s ? data_b_i : data_a_i;
          gnt_a_d     = ~pick_b_s;
          gnt_b_d     = pick_b_s;
          last_b_d    = pick_b_s;
          bcd_valid_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_ADD: begin
            acc_d = sum_s[7:0];
            ov_d  = ov_q | sum_s[8];
          end
          OP_SUB: begin
            acc_d = acc_q - data_q;
            ov_d  = ov_q | (data_q > acc_q);
          end
          OP_LOAD:  acc_d = data_q;
          OP_CLEAR: begin
            acc_d = 8'd0;
            ov_d  = 1'b0;
          end
          default:  acc_d = acc_q;
        endcase
        shift_d = {12'h000, acc_d};
        cnt_d   = 3'd0;
        state_d = ST_CONVERT;
      end
      ST_CONVERT: begin
        shift_d = dd_step(shift_q);
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d     = ST_DONE;
          bcd_d       = shift_d[19:8];
          bcd_valid_d = 1'b1;
          done_d      = 1'b1;
        end else begin
          state_d = ST_CONVERT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      op_q        <= 2'b00;
      data_q      <= 8'd0;
      acc_q       <= 8'd0;
      ov_q        <= 1'b0;
      shift_q     <= 20'd0;
      cnt_q       <= 3'd0;
      bcd_q       <= 12'h000;
      bcd_valid_q <= 1'b1;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      last_b_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      acc_q       <= acc_d;
      ov_q        <= ov_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      last_b_q    <= last_b_d;
    end
  end

  assign gnt_a_o     = gnt_a_q;
  assign gnt_b_o     = gnt_b_q;
  assign acc_o       = acc_q;
  assign overflow_o  = ov_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign bcd_o       = bcd_q;
  assign bcd_valid_o = bcd_valid_q;

endmodule
